// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, RV opcodes,
// and the decode that tells whether an opcode reads rs2.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Only R-type, stores and branches actually source rs2.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OP_RTYPE, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      OP_ITYPE, OP_LOAD:             uses_rs2 = 1'b0;
      default:                       uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: load in EX writes a register the ID
// instruction reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] id_opcode_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  output logic       hazard_o
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = (ex_rd_i == id_rs1_i);
  assign rs2_match = uses_rs2(id_opcode_i) && (ex_rd_i == id_rs2_i);
  assign hazard_o  = ex_memread_i && (ex_rd_i != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: PC/IF-ID/ID-EX enables for load-use, branch flush and
// data-memory waits. Optional PIPE_HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  id_opcode_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        id_branch_taken_i,
  input  logic        mem_busy_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        pipe_hold_o,
  output logic        mem_timeout_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic              timeout_q;
  logic              hazard;

  load_use_detect u_load_use_detect (
    .id_opcode_i  (id_opcode_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .ex_memread_i (ex_memread_i),
    .ex_rd_i      (ex_rd_i),
    .hazard_o     (hazard)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and pipeline controls; a MEM_WAIT release cycle behaves like RUN.
  always_comb begin
    state_d       = state_q;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    case (state_q)
      IDLE: begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        if (start_i) state_d = RUN;
      end
      RUN, MEM_WAIT: begin
        if (mem_busy_i) begin
          pipe_hold_o = 1'b1;
        end else if (hazard) begin
          idex_bubble_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = id_branch_taken_i;
        end
        if (state_q == RUN) begin
          if (!start_i)        state_d = IDLE;
          else if (mem_busy_i) state_d = MEM_WAIT;
        end else if (!mem_busy_i) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wait_cnt_inc = wait_cnt_q + WAIT_W'(1);

  // Wait watchdog: counter saturates at MAX_WAIT, flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q == MEM_WAIT) begin
      if (!mem_busy_i) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_inc;
        if (wait_cnt_inc == WAIT_MAX) timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout_o = timeout_q;
  assign state_o       = state_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        stall_inc;
  logic        flush_inc;

  assign stall_inc = (state_q == MEM_WAIT) || ((state_q == RUN) && hazard);
  assign flush_inc = (state_q != IDLE) && ifid_flush_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_inc) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level
// behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MAX_WAIT = 15;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [6:0]  id_opcode_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        ex_memread_i;
  logic [4:0]  ex_rd_i;
  logic        id_branch_taken_i;
  logic        mem_busy_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        pipe_hold_o;
  logic        mem_timeout_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .id_opcode_i       (id_opcode_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .ex_memread_i      (ex_memread_i),
    .ex_rd_i           (ex_rd_i),
    .id_branch_taken_i (id_branch_taken_i),
    .mem_busy_i        (mem_busy_i),
    .pc_write_o        (pc_write_o),
    .ifid_write_o      (ifid_write_o),
    .ifid_flush_o      (ifid_flush_o),
    .idex_bubble_o     (idex_bubble_o),
    .pipe_hold_o       (pipe_hold_o),
    .mem_timeout_o     (mem_timeout_o),
    .state_o           (state_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model: mode 0 idle, 1 running, 2 waiting on memory.
  int          m_mode;
  int          m_wait;
  bit          m_to;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hazard(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                      input bit mr, input logic [4:0] rd);
    bit reads_rs2;
    reads_rs2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return mr && rd != 5'd0 && (rd == r1 || (reads_rs2 && rd == r2));
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_wait  = 0;
    m_to    = 0;
    m_stall = 32'd0;
    m_flush = 32'd0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".state"},   32'(state_o), 32'd0);
    check({tag, ".pc"},      32'(pc_write_o), 32'd0);
    check({tag, ".ifid_we"}, 32'(ifid_write_o), 32'd0);
    check({tag, ".flush"},   32'(ifid_flush_o), 32'd1);
    check({tag, ".bubble"},  32'(idex_bubble_o), 32'd1);
    check({tag, ".hold"},    32'(pipe_hold_o), 32'd0);
    check({tag, ".tmo"},     32'(mem_timeout_o), 32'd0);
    check({tag, ".stall"},   stall_cnt_o, 32'd0);
    check({tag, ".fcnt"},    flush_cnt_o, 32'd0);
  endtask

  // Drive one cycle of inputs, compare every output with the model, advance the model.
  task automatic step(input string tag, input bit st, input logic [6:0] op, input logic [4:0] r1,
                      input logic [4:0] r2, input bit mr, input logic [4:0] rd, input bit br, input bit busy);
    bit hz;
    bit e_pc, e_we, e_fl, e_bb, e_hd;
    @(negedge clk_i);
    start_i = st; id_opcode_i = op; id_rs1_i = r1; id_rs2_i = r2;
    ex_memread_i = mr; ex_rd_i = rd; id_branch_taken_i = br; mem_busy_i = busy;
    #1;
    hz = model_hazard(op, r1, r2, mr, rd);
    {e_pc, e_we, e_fl, e_bb, e_hd} = 5'b00000;
    if (m_mode == 0)  {e_fl, e_bb} = 2'b11;
    else if (busy)    e_hd = 1'b1;
    else if (hz)      e_bb = 1'b1;
    else              {e_pc, e_we, e_fl} = {1'b1, 1'b1, br};
    check({tag, ".state"},   32'(state_o), 32'(m_mode));
    check({tag, ".pc"},      32'(pc_write_o), 32'(e_pc));
    check({tag, ".ifid_we"}, 32'(ifid_write_o), 32'(e_we));
    check({tag, ".flush"},   32'(ifid_flush_o), 32'(e_fl));
    check({tag, ".bubble"},  32'(idex_bubble_o), 32'(e_bb));
    check({tag, ".hold"},    32'(pipe_hold_o), 32'(e_hd));
    check({tag, ".tmo"},     32'(mem_timeout_o), 32'(m_to));
    check({tag, ".stall"},   stall_cnt_o, m_stall);
    check({tag, ".fcnt"},    flush_cnt_o, m_flush);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    if (m_mode == 2 || (m_mode == 1 && hz)) m_stall = m_stall + 32'd1;
    if (m_mode != 0 && e_fl)                m_flush = m_flush + 32'd1;
`endif
    case (m_mode)
      0: m_mode = st ? 1 : 0;
      1: m_mode = !st ? 0 : (busy ? 2 : 1);
      default: begin
        if (busy) begin
          if (m_wait < int'(MAX_WAIT)) m_wait++;
          if (m_wait >= int'(MAX_WAIT)) m_to = 1;
        end else begin
          m_wait = 0;
          m_mode = 1;
        end
      end
    endcase
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    model_reset();
    check_idle(tag);
    @(negedge clk_i);
    start_i = 1'b0;
    mem_busy_i = 1'b0;
    rst_i = 1'b1;
  endtask

  logic [6:0] ops [0:5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};

  initial begin
    int burst;
    bit busy;
    rst_i = 1'b0; start_i = 1'b0; id_opcode_i = 7'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    ex_memread_i = 1'b0; ex_rd_i = 5'd0; id_branch_taken_i = 1'b0; mem_busy_i = 1'b0;
    #2;
    model_reset();
    check_idle("rst");
    @(negedge clk_i);
    rst_i = 1'b1;

    // Start-up, then load-use cases: add rs2 match, addi rs1 match, rd=x0, addi rs2-only.
    step("idle", 1, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    step("run",  1, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    step("lu_add",  1, 7'b0110011, 5'd2, 5'd5, 1, 5'd5, 0, 0);
    step("lu_addi", 1, 7'b0010011, 5'd5, 5'd0, 1, 5'd5, 0, 0);
    step("lu_x0",   1, 7'b0110011, 5'd0, 5'd0, 1, 5'd0, 0, 0);
    step("lu_irs2", 1, 7'b0010011, 5'd1, 5'd5, 1, 5'd5, 0, 0);
    // Branch alone, then branch with a load-use hazard.
    step("br",    1, 7'b1100011, 5'd3, 5'd4, 0, 5'd0, 1, 0);
    step("br_lu", 1, 7'b1100011, 5'd3, 5'd4, 1, 5'd4, 1, 0);
    step("br_re", 1, 7'b1100011, 5'd3, 5'd4, 0, 5'd0, 1, 0);
    // Three busy cycles then release.
    for (int i = 0; i < 3; i++) step("busy3", 1, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 1);
    step("rel", 1, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    step("rel2", 1, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    // Watchdog: 20 busy cycles, start dropped mid-wait is ignored.
    for (int i = 0; i < 20; i++) step("busy20", (i != 10), 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 1);
    for (int i = 0; i < 3; i++) step("post_to", 1, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    for (int i = 0; i < 2; i++) step("busy_again", 1, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 1);
    async_reset("rst_wait");
    step("idle2", 1, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0);

    // Random traffic with small register indices so hazards are frequent.
    burst = 0;
    for (int n = 0; n < 800; n++) begin
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = int'($urandom_range(1, 20));
      busy = (burst > 0);
      if (burst > 0) burst--;
      step("rnd", ($urandom_range(0, 24) != 0), ops[$urandom_range(0, 5)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), busy);
      if (n == 400) async_reset("rst_rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Decides each cycle whether PC and IF/ID advance, stall, flush or bubble.
- Covers load-use hazards, taken branches resolved in ID, and multi-cycle data-memory waits with a timeout watchdog.
- Sits beside the ID stage. Drives the write enables of PC, IF/ID, ID/EX and the back-end pipeline registers.

Parameters:
- MAX_WAIT, 15: maximum consecutive MEM_WAIT cycles before timeout flag (1..255).
- WAIT_W, $clog2(MAX_WAIT+1): wait counter width (derived, not overridden).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  CPU run enable
- id_opcode_i  in  7  opcode of instruction in ID
- id_rs1_i  in  5  rs1 field in ID
- id_rs2_i  in  5  rs2 field in ID
- ex_memread_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination register of instruction in EX
- id_branch_taken_i  in  1  beq in ID resolved taken
- mem_busy_i  in  1  data memory not ready this cycle
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID register enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_bubble_o  out  1  ID/EX loads control-zero bubble
- pipe_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
- mem_timeout_o  out  1  sticky watchdog flag
- state_o  out  2  current FSM state (debug)
- stall_cnt_o  out  32  performance: stall cycles
- flush_cnt_o  out  32  performance: flush events

Behaviour:
- States: IDLE=0, RUN=1, MEM_WAIT=2. Reset → IDLE, wait counter 0, mem_timeout_o 0, counters 0.
- Outputs are combinational from state and inputs. Only state, counter, timeout and performance counters are registered.

State transitions:
- IDLE: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_hold=0. Goes to RUN when start_i=1.
- RUN:
  - start_i=0 → IDLE (priority over everything).
  - Else mem_busy_i=1 → MEM_WAIT. That same cycle applies hold outputs.
  - Else stays in RUN.
- MEM_WAIT:
  - Hold outputs: pc_write=0, ifid_write=0, pipe_hold=1, flush=0, bubble=0.
  - Counter increments each cycle.
  - mem_busy_i=0 → RUN, counter cleared. The release cycle outputs normal RUN values.
  - If the counter reaches MAX_WAIT with mem_busy_i still 1, mem_timeout_o is set. It stays set until reset; the FSM keeps waiting.
  - start_i is ignored in MEM_WAIT.

RUN priority, highest first:
1. mem_busy_i: hold outputs.
2. Load-use hazard: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
3. Branch taken: pc_write=1, ifid_write=1, ifid_flush=1.
4. Otherwise: pc_write=1, ifid_write=1, all others 0.

Load-use hazard definition:
- Fires when ex_memread_i=1, ex_rd_i≠0, and either ex_rd_i==id_rs1_i or (uses_rs2 and ex_rd_i==id_rs2_i).
- uses_rs2 is true for opcodes 0110011 (R), 0100011 (sd) and 1100011 (beq). It is false for 0010011 (addi) and 0000011 (lw).
- A hazard lasts exactly one cycle, because the load advances to MEM next cycle.
- Hazard plus branch in the same cycle: the flush is suppressed, and the branch re-resolves on the next cycle with forwarded data.

Reset asserted mid-operation: immediate return to IDLE with all outputs at IDLE values.

Optional Feature:
- Macro PIPE_HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments in every RUN cycle with a load-use hazard and every MEM_WAIT cycle.
  - flush_cnt_o increments on every cycle with ifid_flush_o=1 in RUN.
  - Both counters are 32-bit and wrap at 2^32−1 → 0.
- Undefined: both ports are driven constant 0 and no counter flops are inferred.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding constants IDLE/RUN/MEM_WAIT;
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH;
  - the uses_rs2 decode function.
- Sub-module load_use_detect: purely combinational. Inputs are the opcode, rs1/rs2, ex_memread and ex_rd; output is hazard_o. It is instantiated once.

Test Plan:
1. Reset then start_i=1 → state_o 0 then 1. Outputs during IDLE: pc_write_o=0, ifid_flush_o=1.
2. EX lw x5, ID add x1,x2,x5 (opcode 0110011, rs2=5) → one cycle with pc_write_o=0, idex_bubble_o=1. Repeat with addi x1,x5,4 → hazard. Repeat with ex_rd_i=0 → no hazard.
3. id_branch_taken_i=1 with no hazard → ifid_flush_o=1, pc_write_o=1, flush_cnt_o +1. With a simultaneous load-use hazard → ifid_flush_o=0, idex_bubble_o=1.
4. mem_busy_i high for 3 cycles → state_o=2, pipe_hold_o=1 for 3 cycles, then back to RUN. stall_cnt_o +3 when PIPE_HAZARD_PERF_CNT_EN is defined, 0 when undefined.
5. mem_busy_i held for 20 cycles with MAX_WAIT=15 → mem_timeout_o rises after the 15th wait cycle and stays 1 after busy drops.
6. Assert rst_i low during MEM_WAIT → immediate IDLE, mem_timeout_o=0, counters 0.
